// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide side unit owning the HI/LO pair, with busy/done handshake to the hazard unit.
// Define HILO_DIV_EN to build the divider; without it DIV/DIVU complete as no-ops that leave HI/LO unchanged.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO and disabled divides complete from here
// RUN   | one multiply/divide bit per cycle, WIDTH cycles
// FIX   | sign correction of product or quotient/remainder
// ACC   | MADD/MSUB accumulate against {hi,lo}
// WB    | write HI/LO and pulse done

module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             kill,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_ACC  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state, state_d;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               done_pend;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               accept;
    logic               iter_op;
    logic               is_acc;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_neg;
    logic [2*WIDTH-1:0] hilo_acc;

    // A pending MTHI/MTLO done blocks acceptance so done never overlaps a new op's busy.
    assign accept    = (state == S_IDLE) && start && !kill && !done_pend;
    assign op_signed = (op != OP_MULTU) && (op != OP_DIVU);
    assign a_neg     = op_signed && rs_val[WIDTH-1];
    assign b_neg     = op_signed && rt_val[WIDTH-1];
    assign a_mag     = a_neg ? -rs_val : rs_val;
    assign b_mag     = b_neg ? -rt_val : rt_val;
    assign is_acc    = (op_q == OP_MADD) || (op_q == OP_MSUB);

    assign mul_addend = prod[0] ? opnd_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign prod_neg   = -prod;
    assign hilo_acc   = (op_q == OP_MSUB) ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);

`ifdef HILO_DIV_EN
    logic               rneg_q;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    assign iter_op   = (op != OP_MTHI) && (op != OP_MTLO);
    assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    // With a zero divisor the remainder ends up as the dividend magnitude, so re-signing it
    // yields the latched dividend; only the quotient needs forcing to all ones.
    assign rem_fix   = rneg_q ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    assign quo_fix   = (opnd_q == '0) ? '1 : (neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
`else
    assign iter_op   = !op[2];
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept && iter_op) state_d = S_RUN;
            S_RUN: begin
                if (kill)             state_d = S_IDLE;
                else if (cnt == '0)   state_d = S_FIX;
            end
            S_FIX: begin
                if (kill)             state_d = S_IDLE;
                else if (is_acc)      state_d = S_ACC;
                else                  state_d = S_WB;
            end
            S_ACC:   state_d = kill ? S_IDLE : S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q      <= '0;
            opnd_q    <= '0;
            prod      <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            done_pend <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef HILO_DIV_EN
            rneg_q    <= 1'b0;
`endif
        end else begin
            done_q    <= done_pend || ((state == S_WB) && !kill);
            done_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi_q      <= rs_val;
                            done_pend <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo_q      <= rs_val;
                            done_pend <= 1'b1;
                        end else if (!iter_op) begin
                            done_pend <= 1'b1;
                        end else begin
                            op_q   <= op;
                            opnd_q <= b_mag;
                            prod   <= {{WIDTH{1'b0}}, a_mag};
                            neg_q  <= a_neg ^ b_neg;
                            cnt    <= CNT_W'(WIDTH - 1);
`ifdef HILO_DIV_EN
                            rneg_q <= a_neg;
`endif
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
`ifdef HILO_DIV_EN
                    if (op_q[2]) prod <= {div_rem, prod[WIDTH-2:0], div_ge};
                    else
`endif
                    prod <= {mul_sum, prod[WIDTH-1:1]};
                end
                S_FIX: begin
`ifdef HILO_DIV_EN
                    if (op_q[2]) prod <= {rem_fix, quo_fix};
                    else
`endif
                    if (neg_q) prod <= prod_neg;
                end
                S_ACC: prod <= hilo_acc;
                S_WB: begin
                    if (!kill) begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: transaction-level reference model plus directed literal checks.
// Follows HILO_DIV_EN the same way the design does.

module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic         kill = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

`ifdef HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op(op), .kill(kill),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of an iterative op from plain 64-bit arithmetic, and its latency in cycles.
    function automatic void predict(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] hv, input logic [W-1:0] lv,
                                    output logic [W-1:0] ph, output logic [W-1:0] pl, output int lat);
        logic [63:0] p;
        longint q;
        longint r;
        p = '0;
        lat = (o == 3'd2 || o == 3'd3) ? W + 3 : W + 2;
        case (o)
            3'd0: p = longint'($signed(a)) * longint'($signed(b));
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: p = {hv, lv} + longint'($signed(a)) * longint'($signed(b));
            3'd3: p = {hv, lv} - longint'($signed(a)) * longint'($signed(b));
            3'd4: begin
                if (b == '0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd5: begin
                if (b == '0) p = {a, 32'hFFFF_FFFF};
                else         p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        ph = p[63:32];
        pl = p[31:0];
    endfunction

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    bit           m_done = 1'b0;
    bit           m_pdone = 1'b0;
    int           m_rem = 0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_pdone = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_pdone) begin
                m_done  = 1'b1;
                m_pdone = 1'b0;
            end else if (m_rem > 0) begin
                if (kill) m_rem = 0;
                else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                    end
                end
            end else if (start && !kill) begin
                case (op)
                    3'd6: begin m_hi = rs_val; m_pdone = 1'b1; end
                    3'd7: begin m_lo = rs_val; m_pdone = 1'b1; end
                    3'd4, 3'd5: begin
                        if (DIV_EN) predict(op, rs_val, rt_val, m_hi, m_lo, p_hi, p_lo, m_rem);
                        else        m_pdone = 1'b1;
                    end
                    default: predict(op, rs_val, rt_val, m_hi, m_lo, p_hi, p_lo, m_rem);
                endcase
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", {63'b0, busy}, {63'b0, (m_rem > 0)});
            check("done", {63'b0, done}, {63'b0, m_done});
            check("hi", {32'b0, hi}, {32'b0, m_hi});
            check("lo", {32'b0, lo}, {32'b0, m_lo});
        end
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge Clk);
        while ((m_rem > 0 || m_pdone) && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 200) check("idle_timeout", 64'(guard), 64'd0);
    endtask

    // Issues one op from idle; returns the cycle index (accept edge = 0) at which done is seen.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        wait_idle();
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge Clk);
            lat++;
        end
        if (lat >= 200) check("done_timeout", 64'(lat), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        repeat (2) @(negedge Clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        Reset = 1'b0;
        chk_en = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'b0, lo}, 64'hFFFF_FFF1);
        check("model_mult_lo", {32'b0, m_lo}, 64'hFFFF_FFF1);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, lat);
        check("multu_hi", {32'b0, hi}, 64'h4);
        check("multu_lo", {32'b0, lo}, 64'hFFFF_FFF1);

        run_op(3'd7, 32'h10, 32'd0, lat);
        check("mtlo_lat", 64'(lat), 64'd1);
        run_op(3'd6, 32'h0, 32'd0, lat);
        check("mthi_hi", {32'b0, hi}, 64'h0);
        run_op(3'd2, 32'd4, 32'd5, lat);
        check("madd_lat", 64'(lat), 64'd35);
        check("madd_lo", {32'b0, lo}, 64'h24);
        check("madd_hi", {32'b0, hi}, 64'h0);
        run_op(3'd3, 32'd4, 32'd5, lat);
        check("msub_lo", {32'b0, lo}, 64'h10);
        check("model_msub_lo", {32'b0, m_lo}, 64'h10);

`ifdef HILO_DIV_EN
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", 64'(lat), 64'd34);
        check("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        run_op(3'd4, 32'd9, 32'd0, lat);
        check("div0_lo", {32'b0, lo}, 64'hFFFF_FFFF);
        check("div0_hi", {32'b0, hi}, 64'h9);
`else
        run_op(3'd4, 32'd8, 32'd2, lat);
        check("nodiv_lat", 64'(lat), 64'd1);
        check("nodiv_hi", {32'b0, hi}, 64'h0);
        check("nodiv_lo", {32'b0, lo}, 64'h10);
`endif

        run_op(3'd7, 32'h10, 32'd0, lat);
        run_op(3'd6, 32'h0, 32'd0, lat);
        wait_idle();
        start = 1'b1; op = 3'd0; rs_val = 32'd7; rt_val = 32'd9;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        start = 1'b1; op = 3'd6; rs_val = 32'hDEAD_BEEF;
        @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
        check("kill_busy_before", {63'b0, busy}, 64'd1);
        kill = 1'b1;
        @(negedge Clk);
        kill = 1'b0;
        check("kill_busy", {63'b0, busy}, 64'd0);
        check("kill_done", {63'b0, done}, 64'd0);
        check("kill_hi", {32'b0, hi}, 64'h0);
        check("kill_lo", {32'b0, lo}, 64'h10);

        wait_idle();
        start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd3;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        #2 Reset = 1'b1;
        @(negedge Clk);
        check("rstrun_busy", {63'b0, busy}, 64'd0);
        check("rstrun_done", {63'b0, done}, 64'd0);
        check("rstrun_lo", {32'b0, lo}, 64'h0);
        #2 Reset = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            @(negedge Clk);
            start  = ($urandom_range(0, 2) == 0);
            op     = 3'($urandom_range(0, 7));
            rs_val = rand_opnd();
            rt_val = rand_opnd();
            kill   = ($urandom_range(0, 59) == 0);
        end
        @(negedge Clk);
        start = 1'b0;
        kill  = 1'b0;
        wait_idle();
        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
